// File: rtl/phy_tx_lane_arbiter.sv
// Four-lane round-robin transmit arbiter with burst hold, feeding a one-deep
// registered output stage with valid/ready back-pressure.
module phy_tx_lane_arbiter #(
    parameter int         BURST    = 4,
    parameter logic [7:0] IDLE_SYM = 8'hBC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] In0,
    input  logic [7:0] In1,
    input  logic [7:0] In2,
    input  logic [7:0] In3,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       valid2,
    input  logic       valid3,
    output logic       ready0,
    output logic       ready1,
    output logic       ready2,
    output logic       ready3,
    input  logic       out_ready,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] grant_lane,
    output logic       grant_active
);

    // Handshake: a lane byte moves when valid_i and ready_i are both high on a
    // rising edge; data_out is consumed when valid_out and out_ready are both high.

    typedef enum logic {S_IDLE = 1'b0, S_SERVE = 1'b1} state_t;

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cur_q, cur_d;
    logic [3:0] count_q, count_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    logic [3:0] lane_valid;
    logic [7:0] lane_data [4];
    logic       load_en;
    logic       sel_found;
    logic [1:0] sel;
    logic [1:0] cand;
    logic       xfer;
    logic [3:0] ready_vec;

    assign lane_valid = {valid3, valid2, valid1, valid0};
    assign lane_data[0] = In0;
    assign lane_data[1] = In1;
    assign lane_data[2] = In2;
    assign lane_data[3] = In3;

    assign load_en = !valid_q || out_ready;

    // Descending scan so the lane closest to ptr wins the last assignment.
    always_comb begin
        sel       = cur_q;
        sel_found = 1'b0;
        cand      = ptr_q;
        if (state_q == S_SERVE) begin
            sel       = cur_q;
            sel_found = 1'b1;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                cand = ptr_q + 2'(k);
                if (lane_valid[cand]) begin
                    sel       = cand;
                    sel_found = 1'b1;
                end
            end
        end
    end

    assign xfer = sel_found && lane_valid[sel] && load_en && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cur_q   <= 2'd0;
            count_q <= 4'd0;
            data_q  <= IDLE_SYM;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Stalls (load_en=0) leave the burst state untouched.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    cur_d = sel;
                    if (BURST_L == 4'd1) begin
                        ptr_d = sel + 2'd1;
                    end else begin
                        state_d = S_SERVE;
                        count_d = 4'd1;
                    end
                end
            end
            S_SERVE: begin
                if (load_en) begin
                    if (!lane_valid[cur_q] || (count_q + 4'd1 == BURST_L)) begin
                        state_d = S_IDLE;
                        ptr_d   = cur_q + 2'd1;
                        count_d = 4'd0;
                    end else begin
                        count_d = count_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_vec = 4'b0000;
        if (sel_found && load_en && !reset) begin
            ready_vec = 4'b0001 << sel;
        end
        data_d  = data_q;
        valid_d = valid_q;
        if (load_en) begin
            if (xfer) begin
                data_d  = lane_data[sel];
                valid_d = 1'b1;
            end else begin
                data_d  = IDLE_SYM;
                valid_d = 1'b0;
            end
        end
    end

    assign ready0       = ready_vec[0];
    assign ready1       = ready_vec[1];
    assign ready2       = ready_vec[2];
    assign ready3       = ready_vec[3];
    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign grant_lane   = cur_q;
    assign grant_active = (state_q == S_SERVE);

endmodule

// File: tb/tb_phy_tx_lane_arbiter.sv
// Directed bench for phy_tx_lane_arbiter: per-lane byte sources feed two
// instances (BURST=4 and BURST=1); output bytes are checked against a queue.
module tb_phy_tx_lane_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out_ready = 1'b1;
  logic clr = 1'b1;
  logic use_b1 = 1'b0;
  logic [3:0] en = 4'b0000;
  logic [7:0] base [4];
  logic [7:0] lim [4];
  logic [7:0] k [4];

  logic [7:0] In0, In1, In2, In3;
  logic valid0, valid1, valid2, valid3;
  logic ready0, ready1, ready2, ready3;
  logic [7:0] data_out;
  logic valid_out;
  logic [1:0] grant_lane;
  logic grant_active;
  logic b1_ready0, b1_ready1, b1_ready2, b1_ready3;
  logic [7:0] b1_data_out;
  logic b1_valid_out;
  logic [1:0] b1_grant_lane;
  logic b1_grant_active;

  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Lane sources: byte k of lane i is base_i + k, offered while k < lim_i.
  assign In0 = base[0] + k[0];
  assign In1 = base[1] + k[1];
  assign In2 = base[2] + k[2];
  assign In3 = base[3] + k[3];
  assign valid0 = en[0] && (k[0] < lim[0]);
  assign valid1 = en[1] && (k[1] < lim[1]);
  assign valid2 = en[2] && (k[2] < lim[2]);
  assign valid3 = en[3] && (k[3] < lim[3]);

  logic [3:0] vld, rdy, rdy_b1, acc;
  assign vld = {valid3, valid2, valid1, valid0};
  assign rdy = {ready3, ready2, ready1, ready0};
  assign rdy_b1 = {b1_ready3, b1_ready2, b1_ready1, b1_ready0};
  assign acc = vld & (use_b1 ? rdy_b1 : rdy);

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      k[i] <= clr ? 8'd0 : k[i] + {7'd0, acc[i]};
    end
  end

  phy_tx_lane_arbiter #(.BURST(4), .IDLE_SYM(8'hBC)) dut (
    .clk(clk), .reset(reset),
    .In0(In0), .In1(In1), .In2(In2), .In3(In3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .ready0(ready0), .ready1(ready1), .ready2(ready2), .ready3(ready3),
    .out_ready(out_ready), .data_out(data_out), .valid_out(valid_out),
    .grant_lane(grant_lane), .grant_active(grant_active)
  );

  phy_tx_lane_arbiter #(.BURST(1), .IDLE_SYM(8'hBC)) dut_b1 (
    .clk(clk), .reset(reset),
    .In0(In0), .In1(In1), .In2(In2), .In3(In3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .ready0(b1_ready0), .ready1(b1_ready1), .ready2(b1_ready2), .ready3(b1_ready3),
    .out_ready(out_ready), .data_out(b1_data_out), .valid_out(b1_valid_out),
    .grant_lane(b1_grant_lane), .grant_active(b1_grant_active)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    clr = 1'b0;
  endtask

  // Pop and compare n output bytes; contig demands valid_out every cycle after the first.
  task automatic drain(input int n, input bit contig, input bit which);
    int got = 0;
    int waited = 0;
    bit started = 1'b0;
    logic vo;
    logic [7:0] d;
    logic [7:0] e;
    while (got < n) begin
      @(negedge clk);
      vo = which ? b1_valid_out : valid_out;
      d = which ? b1_data_out : data_out;
      if (vo && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check(which ? "b1_stream" : "stream", d, e);
        if (which) check("b1_grant_active", {7'd0, b1_grant_active}, 8'd0);
        got++;
        started = 1'b1;
      end else begin
        if (contig && started) check("gap_valid_out", {7'd0, vo}, 8'd1);
        waited++;
        if (waited > 40) begin
          checks++;
          errors++;
          $error("FAIL drain_timeout: observed=%0d bytes expected=%0d", got, n);
          break;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      base[i] = 8'h00;
      lim[i] = 8'd0;
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    clr = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_valid_out", {7'd0, valid_out}, 8'd0);
      check("idle_data_out", data_out, 8'hBC);
      check("idle_ready", {4'd0, rdy}, 8'd0);
      check("idle_grant_active", {7'd0, grant_active}, 8'd0);
    end

    // Fairness: all lanes valid, BURST=4
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      base[i] = 8'h10 * i;
      lim[i] = 8'd100;
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          exp_q.push_back(8'(8'h10 * i + 4 * r + j));
    en = 4'b1111;
    @(negedge clk);
    check("first_ready0", {7'd0, ready0}, 8'd1);
    check("first_valid_out", {7'd0, valid_out}, 8'd0);
    drain(32, 1'b1, 1'b0);
    en = 4'b0000;
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;

    // Lane 2 alone, three bytes then valid drop
    base[2] = 8'hA1;
    lim[2] = 8'd3;
    en = 4'b0100;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    drain(3, 1'b1, 1'b0);
    check("release_cycle_grant_active", {7'd0, grant_active}, 8'd1);
    @(negedge clk);
    check("release_valid_out", {7'd0, valid_out}, 8'd0);
    check("release_data_out", data_out, 8'hBC);
    check("release_grant_active", {7'd0, grant_active}, 8'd0);
    check("release_grant_lane", {6'd0, grant_lane}, 8'd2);
    base[0] = 8'hC0;
    base[3] = 8'hD0;
    lim[0] = 8'd1;
    lim[3] = 8'd1;
    en = 4'b1001;
    #1;
    check("ptr3_ready3", {7'd0, ready3}, 8'd1);
    check("ptr3_ready0", {7'd0, ready0}, 8'd0);
    exp_q.push_back(8'hD0);
    exp_q.push_back(8'hC0);
    drain(2, 1'b0, 1'b0);
    en = 4'b0000;

    // Stall mid-burst, lanes 0 and 1
    do_reset();
    base[0] = 8'h00;
    base[1] = 8'h10;
    lim[0] = 8'd100;
    lim[1] = 8'd100;
    en = 4'b0011;
    exp_q.push_back(8'h00);
    drain(1, 1'b1, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_data_out", data_out, 8'h01);
      check("stall_valid_out", {7'd0, valid_out}, 8'd1);
      check("stall_ready", {4'd0, rdy}, 8'd0);
      check("stall_grant", {5'd0, grant_active, grant_lane}, 8'h04);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h13);
    drain(7, 1'b1, 1'b0);
    en = 4'b0000;

    // BURST=1 instance, lanes 1 and 3 alternate
    do_reset();
    use_b1 = 1'b1;
    base[1] = 8'h50;
    base[3] = 8'h70;
    lim[1] = 8'd4;
    lim[3] = 8'd4;
    en = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back(8'(8'h50 + j));
      exp_q.push_back(8'(8'h70 + j));
    end
    drain(8, 1'b1, 1'b1);
    en = 4'b0000;

    // Reset mid-burst on lane 0
    do_reset();
    use_b1 = 1'b0;
    base[0] = 8'hE0;
    lim[0] = 8'd6;
    en = 4'b0001;
    exp_q.push_back(8'hE0);
    drain(1, 1'b1, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("in_reset_ready0", {7'd0, ready0}, 8'd0);
    check("pre_reset_data_out", data_out, 8'hE1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_valid_out", {7'd0, valid_out}, 8'd0);
    check("post_reset_data_out", data_out, 8'hBC);
    check("post_reset_grant", {5'd0, grant_active, grant_lane}, 8'd0);
    check("post_reset_ready0", {7'd0, ready0}, 8'd1);
    exp_q.push_back(8'hE2);
    exp_q.push_back(8'hE3);
    exp_q.push_back(8'hE4);
    exp_q.push_back(8'hE5);
    drain(4, 1'b1, 1'b0);
    @(negedge clk);
    check("after_burst_valid_out", {7'd0, valid_out}, 8'd0);
    check("after_burst_grant_active", {7'd0, grant_active}, 8'd0);
    check("queue_empty", 8'(exp_q.size()), 8'd0);
    en = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phy_tx_lane_arbiter.md
Name: phy_tx_lane_arbiter

Overview:
- Round-robin arbiter with burst hold for the PHY transmit path.
- Shares the single 8-bit transmit byte stream between four lane requesters (In0..In3 with valid0..valid3).
- Sits between the per-lane input buffers and the serializer/encoder stage.
- Registers one byte per cycle into a one-deep output stage with valid/ready back-pressure, and drives IDLE_SYM when no lane is served.

Parameters:
- BURST, 4: maximum consecutive bytes granted to one lane before the grant rotates (legal 1..15).
- IDLE_SYM, 8'hBC: value driven on data_out whenever valid_out=0.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- In0, In1, In2, In3  in  8 each  lane data bytes.
- valid0, valid1, valid2, valid3  in  1 each  lane byte valid.
- ready0, ready1, ready2, ready3  out  1 each  lane byte accepted this cycle when valid is also high.
- out_ready  in  1  downstream can take data_out this cycle.
- data_out  out  8  registered output byte.
- valid_out  out  1  data_out holds a byte.
- grant_lane  out  2  lane currently holding or last holding the grant (registered cur).
- grant_active  out  1  registered lock flag; a burst is in progress.

Behaviour:
- Clocking: one clock domain; reset is synchronous and active-high, sampled on rising clk.
- Reset values: valid_out=0, data_out=IDLE_SYM, ptr=0, cur=0, lock=0, count=0, so grant_lane=0, grant_active=0. ready0..3 are forced to 0 in any cycle where reset=1.
- load_en = !valid_out || out_ready.
- Lane select:
  - lock=1: sel=cur.
  - lock=0: sel = first lane with valid=1 searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - lock=0 with no valid lane: nothing is selected.
- ready_i (combinational) = (i==sel) && load_en && !reset. All other ready signals are 0.
- Transfer: occurs when valid_sel && ready_sel. At the next edge data_out<=In_sel and valid_out<=1.
- Latency: a byte accepted in cycle N appears on data_out/valid_out in cycle N+1.
- Output stage:
  - load_en=1 with no transfer: valid_out<=0 and data_out<=IDLE_SYM.
  - load_en=0 (valid_out=1, out_ready=0): data_out and valid_out hold and every ready is 0.
- Burst FSM, two states: IDLE (lock=0) and SERVE (lock=1).
  - IDLE, transfer on lane s: if BURST=1, stay IDLE and set ptr<=s+1; otherwise go to SERVE with cur<=s and count<=1. In both cases grant_lane reflects s from the next cycle.
  - SERVE, transfer with count+1==BURST: go to IDLE with ptr<=cur+1 and count<=0.
  - SERVE, transfer with count+1<BURST: count<=count+1.
  - SERVE, valid_cur=0 while load_en=1: release to IDLE with ptr<=cur+1 and count<=0. No byte moves that cycle.
  - SERVE, load_en=0: hold everything. A stall never ends a burst and never counts toward BURST.
- Rotation arithmetic: ptr and cur are 2-bit and wrap 3->0. count width is 4 bits.
- Fairness: with all four lanes continuously valid and out_ready=1, the service order is 0,1,2,3,0,... in blocks of BURST bytes with no bubbles. Output throughput is 1 byte/cycle.
- Release by valid drop costs one idle cycle. The newly selected lane transfers in the following cycle.
- Simultaneous out_ready=1 and a transfer: the old output byte is consumed and the new one is loaded in the same edge.
- Reset mid-burst: the in-flight output byte is discarded (valid_out=0), lock is cleared and ptr=0. A lane's byte presented during a reset cycle is not accepted.
- In0..In3 are only sampled on a transfer. Values on non-selected lanes are don't-care.

Test Plan:
- Reset, then all valid=0 for 5 cycles -> valid_out=0, data_out=8'hBC, ready0..3=0, grant_active=0.
- BURST=4, valid0..3 constantly 1, In_i=8'h10*i+k (k = incrementing per-lane counter), out_ready=1 -> data_out sequence 00,01,02,03,10,11,12,13,20..23,30..33,04..., first byte one cycle after first ready0; no gaps.
- Only lane 2 valid, 3 bytes A1,A2,A3, then valid2=0 -> output A1,A2,A3, then one idle (BC). grant_active drops after the idle release cycle; ptr=3, so lane 3 is checked first next.
- Lanes 0 and 1 valid, out_ready low for 3 cycles mid-burst -> data_out frozen, ready0/1=0, count unchanged; after out_ready=1 the burst finishes exactly 4 lane-0 bytes total.
- BURST=1 override, lanes 1 and 3 valid -> alternation 1,3,1,3 each cycle, grant_active stays 0.
- Assert reset while lane 0 is at count=2 with valid_out=1 -> next cycle valid_out=0, data_out=BC, grant_lane=0, grant_active=0; after release lane 0 is regranted and gets a fresh 4-byte burst.
